// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the multi-cycle MIPS sequencer: state codes,
// opcode/func fields, ALU selects, fault codes and the decode result record.
package mips_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_HALT   = 3'd5;
    localparam state_t ST_FAULT  = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_OVF     = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    // ovf_check marks the signed arithmetic ops whose overflow aborts writeback.
    typedef struct packed {
        logic       legal;
        logic       is_halt;
        logic [2:0] alu_op;
        logic       ovf_check;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps the latched IR to legality,
// halt detection, ALU select and whether ALU overflow must be honoured.
module mc_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output dec_t        dec
);

    logic [5:0] opcode;
    logic [5:0] func;

    assign opcode = ir[31:26];
    assign func   = ir[5:0];

    always_comb begin
        dec = '0;
        if (opcode == OP_HALT) begin
            dec.is_halt = 1'b1;
        end else if (opcode == OP_RTYPE) begin
            case (func)
                FN_ADD: begin dec.legal = 1'b1; dec.alu_op = ALU_ADD; dec.ovf_check = 1'b1; end
                FN_SUB: begin dec.legal = 1'b1; dec.alu_op = ALU_SUB; dec.ovf_check = 1'b1; end
                FN_AND: begin dec.legal = 1'b1; dec.alu_op = ALU_AND; end
                FN_OR:  begin dec.legal = 1'b1; dec.alu_op = ALU_OR;  end
                FN_SLT: begin dec.legal = 1'b1; dec.alu_op = ALU_SLT; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller with imem req/ack handshake,
// run/single-step control, halt/fault states and a retired-instruction counter.
module mc_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             clear_fault,
    input  logic [31:0]      instr_in,
    input  logic             imem_ack,
    input  logic             alu_overflow,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_write,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired
);

    localparam logic [7:0] TMO_LAST = 8'(IMEM_TIMEOUT - 1);

    state_t      state;
    logic [31:0] ir;
    logic [7:0]  tmo_cnt;
    logic        step_mode;
    logic [1:0]  fcode;
    dec_t        dec;
    logic        wb_ovf;
    logic        in_fetch;
    logic        in_wb;

    mc_decode u_decode (
        .ir  (ir),
        .dec (dec)
    );

    assign in_fetch = (state == ST_FETCH);
    assign in_wb    = (state == ST_WB);
    assign wb_ovf   = alu_overflow & dec.ovf_check;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ir        <= '0;
            tmo_cnt   <= '0;
            step_mode <= 1'b0;
            fcode     <= FC_NONE;
            retired   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run | step) begin
                        state     <= ST_FETCH;
                        step_mode <= ~run;
                        tmo_cnt   <= '0;
                    end
                end
                // The timeout fires on the IMEM_TIMEOUT-th unanswered cycle, so an
                // ack arriving in that same cycle still takes the fetch.
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= instr_in;
                        state <= ST_DECODE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= ST_FAULT;
                        fcode <= FC_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_DECODE: begin
                    if (dec.is_halt) begin
                        state <= ST_HALT;
                    end else if (dec.legal) begin
                        state <= ST_EXEC;
                    end else begin
                        state <= ST_FAULT;
                        fcode <= FC_ILLEGAL;
                    end
                end
                ST_EXEC: state <= ST_WB;
                ST_WB: begin
                    if (wb_ovf) begin
                        state <= ST_FAULT;
                        fcode <= FC_OVF;
                    end else begin
                        retired <= retired + CNT_W'(1);
                        if (run & ~step_mode) begin
                            state   <= ST_FETCH;
                            tmo_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HALT: ;
                ST_FAULT: begin
                    if (clear_fault) begin
                        state <= ST_IDLE;
                        fcode <= FC_NONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Writeback strobes react to alu_overflow in the WB cycle itself.
    assign imem_req   = in_fetch;
    assign ir_load    = in_fetch & imem_ack;
    assign reg_write  = in_wb & ~wb_ovf;
    assign pc_write   = in_wb & ~wb_ovf;
    assign alu_op     = (state == ST_EXEC || in_wb) ? dec.alu_op : ALU_AND;
    assign halted     = (state == ST_HALT);
    assign fault      = (state == ST_FAULT);
    assign fault_code = fcode;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed vector table, hand corner
// sequences and random programs checked against a cycle timeline model.
module tb_mc_sequencer;

    localparam int TMO = 15;
    localparam int CW  = 16;
    localparam int TL  = 1024;

    logic        clk = 1'b0;
    logic        rst, run, step, clear_fault, imem_ack, alu_overflow;
    logic [31:0] instr_in;
    logic        imem_req, ir_load, pc_write, reg_write, halted, fault;
    logic [2:0]  alu_op;
    logic [1:0]  fault_code;
    logic [CW-1:0] retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_sequencer #(.IMEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .clear_fault(clear_fault),
        .instr_in(instr_in), .imem_ack(imem_ack), .alu_overflow(alu_overflow),
        .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write), .alu_op(alu_op),
        .reg_write(reg_write), .halted(halted), .fault(fault), .fault_code(fault_code),
        .retired(retired)
    );

    typedef struct packed {
        logic        req, rw, pw;
        logic [2:0]  alu;
        logic        halt, flt;
        logic [1:0]  code;
        logic [15:0] ret;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        int          dly;
        bit          ovf;
        logic [2:0]  alu;
        int          rw;
        logic [1:0]  code;
    } vec_t;

    obs_t          exp_tl [TL];
    logic [31:0]   p_instr[$];
    int            p_dly[$];
    bit            p_ovf[$];
    logic [15:0]   mret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.req = imem_req; o.rw = reg_write; o.pw = pc_write; o.alu = alu_op;
        o.halt = halted; o.flt = fault; o.code = fault_code; o.ret = retired;
        return o;
    endfunction

    // 0 = executable R-type, 1 = halt, 2 = illegal
    function automatic int kind_of(input logic [31:0] w);
        int op, fn;
        op = int'(w >> 26);
        fn = int'(w & 32'h3F);
        if (op == 63) return 1;
        if (op == 0 && (fn == 32 || fn == 34 || fn == 36 || fn == 37 || fn == 42)) return 0;
        return 2;
    endfunction

    function automatic logic [2:0] alu_of(input logic [31:0] w);
        int fn;
        fn = int'(w & 32'h3F);
        case (fn)
            36: return 3'b000;
            37: return 3'b001;
            32: return 3'b010;
            34: return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    function automatic bit is_addsub(input logic [31:0] w);
        int fn;
        fn = int'(w & 32'h3F);
        return (fn == 32 || fn == 34);
    endfunction

    task automatic fill_fault(input int c0, input logic [1:0] code);
        for (int c = c0; c < TL; c++) begin exp_tl[c].flt = 1'b1; exp_tl[c].code = code; end
    endtask

    task automatic fill_halt(input int c0);
        for (int c = c0; c < TL; c++) exp_tl[c].halt = 1'b1;
    endtask

    task automatic fill_ret(input int c0, input logic [15:0] r);
        for (int c = c0; c < TL; c++) exp_tl[c].ret = r;
    endtask

    // Timeline model: cycle 1 is the first fetch cycle; fetch lasts dly+1 cycles,
    // then one cycle each of decode, exec and writeback.
    task automatic build_tl(input bit run_mode, input int drop_c, input logic [15:0] ret0,
                            output int last, output logic [15:0] ret_end);
        int t, d, dc, wb, k;
        logic [15:0] r;
        for (int c = 0; c < TL; c++) begin exp_tl[c] = '0; exp_tl[c].ret = ret0; end
        t = 1; r = ret0; last = 1;
        for (int i = 0; i < p_instr.size(); i++) begin
            if (t > TL - 40) break;
            d = p_dly[i];
            if (d >= TMO) begin
                for (int c = t; c < t + TMO; c++) exp_tl[c].req = 1'b1;
                fill_fault(t + TMO, 2'b11); last = t + TMO; break;
            end
            for (int c = t; c <= t + d; c++) exp_tl[c].req = 1'b1;
            dc = t + d + 1;
            k  = kind_of(p_instr[i]);
            if (k == 1) begin fill_halt(dc + 1); last = dc + 1; break; end
            if (k == 2) begin fill_fault(dc + 1, 2'b01); last = dc + 1; break; end
            wb = dc + 2;
            exp_tl[dc + 1].alu = alu_of(p_instr[i]);
            exp_tl[wb].alu     = alu_of(p_instr[i]);
            if (p_ovf[i] && is_addsub(p_instr[i])) begin
                fill_fault(wb + 1, 2'b10); last = wb + 1; break;
            end
            exp_tl[wb].rw = 1'b1; exp_tl[wb].pw = 1'b1;
            r = r + 16'd1;
            fill_ret(wb + 1, r);
            last = wb + 1;
            if (!run_mode || wb >= drop_c) break;
            t = wb + 1;
        end
        ret_end = r;
    endtask

    // Drives the program through a memory responder and checks every cycle
    // against the timeline; mid_step pulses step at that cycle (should be ignored).
    task automatic run_prog(input bit run_mode, input bit step_too, input int drop_c,
                            input int mid_step, output int rw_cnt, output logic [2:0] alu_wb);
        int last, idx, wcnt;
        logic [15:0] ret_end;
        obs_t a;
        build_tl(run_mode, drop_c, mret, last, ret_end);
        idx = 0; wcnt = 0; rw_cnt = 0; alu_wb = '0;
        @(negedge clk);
        run  = run_mode;
        step = !run_mode || step_too;
        for (int c = 1; c <= last + 2; c++) begin
            @(negedge clk);
            step = (c == mid_step);
            a = sample();
            chk($sformatf("timeline cyc %0d", c), 64'(a), 64'(exp_tl[c]));
            if (a.rw) rw_cnt++;
            if (c == p_dly[0] + 4) alu_wb = a.alu;
            imem_ack = 1'b0;
            instr_in = $urandom;
            if (imem_req && idx < p_instr.size()) begin
                if (wcnt == p_dly[idx]) begin
                    imem_ack = 1'b1; instr_in = p_instr[idx]; alu_overflow = p_ovf[idx];
                    idx++; wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            #1 chk($sformatf("ir_load cyc %0d", c), 64'(ir_load), 64'(imem_ack & exp_tl[c].req));
            if (c >= drop_c) run = 1'b0;
        end
        imem_ack = 1'b0; run = 1'b0; step = 1'b0;
        mret = ret_end;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; step = 1'b0; clear_fault = 1'b0;
        imem_ack = 1'b1; alu_overflow = 1'b0; instr_in = 32'h0;
        #1 chk("reset outputs", 64'({imem_req, ir_load, pc_write, alu_op, reg_write,
                                       halted, fault, fault_code, retired}), 64'(0));
        imem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mret = '0;
    endtask

    task automatic do_clear();
        @(negedge clk); clear_fault = 1'b1;
        @(negedge clk); clear_fault = 1'b0;
        chk("clear_fault", 64'({fault, fault_code}), 64'(0));
    endtask

    task automatic load1(input logic [31:0] w, input int d, input bit o);
        p_instr = {w}; p_dly = {d}; p_ovf = {o};
    endtask

    vec_t tbl[13];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rw, n, r, drop;
        logic [2:0] alu;
        logic [15:0] prev;
        logic [5:0] fns[5];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        tbl[0]  = '{32'h00221820, 0,  1'b0, 3'b010, 1, 2'b00};
        tbl[1]  = '{32'h00221824, 3,  1'b0, 3'b000, 1, 2'b00};
        tbl[2]  = '{32'h00221825, 3,  1'b0, 3'b001, 1, 2'b00};
        tbl[3]  = '{32'h00221822, 3,  1'b0, 3'b110, 1, 2'b00};
        tbl[4]  = '{32'h0022182A, 3,  1'b0, 3'b111, 1, 2'b00};
        tbl[5]  = '{32'h0022182A, 1,  1'b1, 3'b111, 1, 2'b00};
        tbl[6]  = '{32'h00221824, 0,  1'b1, 3'b000, 1, 2'b00};
        tbl[7]  = '{32'h00221820, 0,  1'b1, 3'b010, 0, 2'b10};
        tbl[8]  = '{32'h00221822, 2,  1'b1, 3'b110, 0, 2'b10};
        tbl[9]  = '{32'h8C000000, 0,  1'b0, 3'b000, 0, 2'b01};
        tbl[10] = '{32'h00221821, 1,  1'b0, 3'b000, 0, 2'b01};
        tbl[11] = '{32'h00221820, 14, 1'b0, 3'b010, 1, 2'b00};
        tbl[12] = '{32'h00221820, 99, 1'b0, 3'b000, 0, 2'b11};

        rst = 1'b1; run = 1'b0; step = 1'b0; clear_fault = 1'b0;
        imem_ack = 1'b0; alu_overflow = 1'b0; instr_in = '0; mret = '0;
        do_reset();

        // Directed vectors, one single-step instruction each.
        for (int i = 0; i < 13; i++) begin
            load1(tbl[i].instr, tbl[i].dly, tbl[i].ovf);
            prev = mret;
            run_prog(1'b0, 1'b0, 100000, -1, rw, alu);
            chk($sformatf("tbl%0d reg_write pulses", i), 64'(rw), 64'(tbl[i].rw));
            chk($sformatf("tbl%0d fault_code", i), 64'(fault_code), 64'(tbl[i].code));
            if (tbl[i].code == 2'b00 || tbl[i].code == 2'b10)
                chk($sformatf("tbl%0d alu_op", i), 64'(alu), 64'(tbl[i].alu));
            chk($sformatf("tbl%0d retired", i), 64'(retired), 64'(prev + 16'(tbl[i].rw)));
            if (tbl[i].code != 2'b00) do_clear();
        end

        // step pulsed again while busy is ignored
        load1(32'h00221820, 2, 1'b0);
        run_prog(1'b0, 1'b0, 100000, 5, rw, alu);
        chk("busy step ignored", 64'(rw), 64'(1));

        // free-running add, then halt; halt is sticky against run/step
        do_reset();
        p_instr = {32'h00221820, 32'hFC000000}; p_dly = {0, 0}; p_ovf = {1'b0, 1'b0};
        run_prog(1'b1, 1'b0, 100000, -1, rw, alu);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("halt sticky", 64'({halted, imem_req, fault}), 64'(3'b100));
            run = 1'b1; step = c[0];
        end
        run = 1'b0; step = 1'b0;

        // reset in the middle of EXEC
        do_reset();
        load1(32'h00221820, 0, 1'b0);
        run_prog(1'b0, 1'b0, 100000, -1, rw, alu);
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0; imem_ack = 1'b1; instr_in = 32'h00221820;
        @(negedge clk); imem_ack = 1'b0;
        @(negedge clk);
        chk("pre-reset exec alu_op", 64'(alu_op), 64'(3'b010));
        chk("pre-reset retired", 64'(retired), 64'(1));
        #1 rst = 1'b1;
        #1 chk("async reset outputs", 64'({imem_req, ir_load, pc_write, alu_op, reg_write,
                                             halted, fault, fault_code, retired}), 64'(0));
        @(negedge clk); rst = 1'b0; mret = '0;

        // random programs in run mode, some with run dropped mid-stream
        for (int p = 0; p < 8; p++) begin
            do_reset();
            p_instr.delete(); p_dly.delete(); p_ovf.delete();
            n = $urandom_range(3, 12);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 15);
                if (r == 0) p_instr.push_back({6'h23, 26'($urandom)});
                else p_instr.push_back({6'h00, 20'($urandom), fns[$urandom_range(0, 4)]});
                p_dly.push_back((r == 1 && p == 5) ? 99 : $urandom_range(0, 5));
                p_ovf.push_back($urandom_range(0, 3) == 0);
            end
            p_instr.push_back({6'h3F, 26'($urandom)}); p_dly.push_back($urandom_range(0, 3));
            p_ovf.push_back(1'b0);
            drop = (p % 2 == 1) ? $urandom_range(3, 40) : 100000;
            run_prog(1'b1, p == 2, drop, -1, rw, alu);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
